// File: rtl/rf_pkg.sv
// Shared definitions for the register-dump reader: default widths and FSM encoding.
package rf_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Valid/ready word stream carrying one dumped register (index + contents).
interface reg_dump_reader_if
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
);

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/dump_out_reg.sv
// Output holding register: captures one word on load, drops valid on clear,
// and never overwrites a word the consumer has not yet accepted.
module dump_out_reg
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    reg_dump_reader_if.master stream
);

    logic              valid_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic              stalled;

    assign stalled = valid_reg && !stream.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (load && !stalled) begin
            valid_reg <= 1'b1;
            addr_reg  <= load_addr;
            data_reg  <= load_data;
        end
    end

    assign stream.out_valid = valid_reg;
    assign stream.out_addr  = addr_reg;
    assign stream.out_data  = data_reg;

endmodule

// File: rtl/reg_dump_reader.sv
// Walks an inclusive register range through an async read port and streams
// each (index, contents) pair out over a valid/ready handshake.
module reg_dump_reader
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    dump_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] counter_reg, counter_next;
    logic [ADDR_W-1:0] last_reg, last_next;
    logic              err_reg, err_next;
    logic              load_en;
    logic              clear_en;
    logic              counter_zero;
    logic [DATA_W-1:0] load_data;

    reg_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) stream_if ();

    // x0 is hard-wired zero regardless of what the storage holds.
    assign counter_zero = (counter_reg == '0);

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_zero_mask
            assign load_data[gi] = rd_data[gi] & ~counter_zero;
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        last_next    = last_reg;
        err_next     = 1'b0;
        load_en      = 1'b0;
        clear_en     = 1'b0;
        if (abort) begin
            state_next = ST_IDLE;
            clear_en   = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (first_addr <= last_addr) begin
                            last_next    = last_addr;
                            counter_next = first_addr;
                            state_next   = ST_READ;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    load_en    = 1'b1;
                    state_next = ST_SEND;
                end
                ST_SEND: begin
                    if (stream_if.out_valid && stream_if.out_ready) begin
                        clear_en = 1'b1;
                        // Stop at the bound instead of incrementing, so the top address never wraps.
                        if (counter_reg == last_reg) begin
                            state_next = ST_DONE;
                        end else begin
                            counter_next = counter_reg + ADDR_W'(1);
                            state_next   = ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            counter_reg <= '0;
            last_reg    <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            last_reg    <= last_next;
            err_reg     <= err_next;
        end
    end

    dump_out_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load_en),
        .clear     (clear_en),
        .load_addr (counter_reg),
        .load_data (load_data),
        .stream    (stream_if.master)
    );

    assign stream_if.out_ready = out_ready;
    assign out_valid = stream_if.out_valid;
    assign out_addr  = stream_if.out_addr;
    assign out_data  = stream_if.out_data;

    assign rd_addr = counter_reg;
    assign busy    = (state_reg != ST_IDLE);
    // A rejected range reports done together with err.
    assign done    = (state_reg == ST_DONE) | err_reg;
    assign err     = err_reg;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: table of ranges, random ranges/backpressure, and
// hand-written abort and reset sequences, all checked against a range model.
module tb_reg_dump_reader;
    import rf_pkg::*;

    localparam int AW = RF_ADDR_W;
    localparam int DW = RF_DATA_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          err;

    reg_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [DW-1:0] regs [0:(1<<AW)-1];
    assign rd_data = regs[rd_addr];

    reg_dump_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (bus.out_valid),
        .out_ready  (bus.out_ready),
        .out_addr   (bus.out_addr),
        .out_data   (bus.out_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [AW-1:0] f;
        logic [AW-1:0] l;
        int            mode;       // 0: ready high, 1: random ready, 2: ready low 4 cycles on first word
        logic          exp_err;
        int            exp_words;  // -1: take the count from the model only
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_dump(input logic [AW-1:0] f, input logic [AW-1:0] l, input int mode,
                           input logic exp_err, input int exp_words, input string tag);
        logic [AW-1:0] exp_a [$];
        logic [DW-1:0] exp_d [$];
        logic [AW-1:0] got_a [$];
        logic [DW-1:0] got_d [$];
        int            hs_cyc [$];
        int            first_valid = -1;
        int            done_cyc = -1;
        int            err_cnt = 0;
        int            hold = 0;
        bit            prev_hold = 0;
        bit            finished = 0;
        logic [AW-1:0] prev_a = '0;
        logic [DW-1:0] prev_d = '0;

        if (int'(f) <= int'(l)) begin
            for (int a = int'(f); a <= int'(l); a++) begin
                exp_a.push_back(AW'(a));
                exp_d.push_back((a == 0) ? 32'h0 : regs[a]);
            end
        end

        start = 1'b1;
        first_addr = f;
        last_addr = l;
        tick();
        start = 1'b0;
        first_addr = AW'($urandom);
        last_addr = AW'($urandom);

        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            case (mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = !(bus.out_valid && hold < 4);
            endcase
            if (bus.out_valid && !bus.out_ready) hold++;
            if (cyc == 0) check({tag, " busy_after_start"}, busy, !exp_err);
            if (prev_hold)
                check({tag, " held_word"}, {bus.out_valid, bus.out_addr, bus.out_data}, {1'b1, prev_a, prev_d});
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            if (bus.out_valid && bus.out_ready) begin
                got_a.push_back(bus.out_addr);
                got_d.push_back(bus.out_data);
                hs_cyc.push_back(cyc);
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_a = bus.out_addr;
            prev_d = bus.out_data;
            if (err) err_cnt++;
            if (done) begin
                done_cyc = cyc;
                finished = 1;
                check({tag, " err_with_done"}, err, exp_err);
            end
            tick();
        end

        check({tag, " finished"}, finished, 1'b1);
        check({tag, " post_idle"}, {busy, done, err, bus.out_valid}, 4'b0000);
        check({tag, " err_count"}, err_cnt, exp_err ? 1 : 0);
        check({tag, " word_count"}, got_a.size(), exp_a.size());
        if (exp_words >= 0) check({tag, " table_words"}, got_a.size(), exp_words);
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            check($sformatf("%s word%0d addr", tag, i), got_a[i], exp_a[i]);
            check($sformatf("%s word%0d data", tag, i), got_d[i], exp_d[i]);
        end
        if (exp_err) begin
            check({tag, " err_done_cycle"}, done_cyc, 0);
            check({tag, " no_valid"}, first_valid, -1);
        end else begin
            check({tag, " counter_at_last"}, rd_addr, l);
            if (hs_cyc.size() > 0)
                check({tag, " done_after_last_hs"}, done_cyc, hs_cyc[hs_cyc.size()-1] + 1);
            if (mode == 0) begin
                check({tag, " first_valid_latency"}, first_valid, 1);
                for (int i = 0; i < hs_cyc.size(); i++)
                    check($sformatf("%s word%0d spacing", tag, i), hs_cyc[i], 1 + 2 * i);
            end
        end
        $display("dump %s first=%0d last=%0d mode=%0d words=%0d err=%0d", tag, f, l, mode, got_a.size(), err_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        logic [AW-1:0] rf;
        logic [AW-1:0] rl;

        regs[0] = 32'hDEADBEEF;
        for (int i = 1; i < (1 << AW); i++)
            regs[i] = (i < 10) ? 32'h11111111 * i : $urandom;

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        first_addr = '0;
        last_addr = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check("reset_state", {busy, done, err, bus.out_valid, bus.out_addr, bus.out_data, rd_addr}, 64'h0);
        rst = 1'b0;
        tick();
        $display("reset checked");

        vecs[0] = '{5'd1,  5'd3,  0, 1'b0, 3};
        vecs[1] = '{5'd0,  5'd1,  0, 1'b0, 2};
        vecs[2] = '{5'd5,  5'd2,  0, 1'b1, 0};
        vecs[3] = '{5'd30, 5'd31, 2, 1'b0, 2};
        vecs[4] = '{5'd7,  5'd7,  0, 1'b0, 1};
        vecs[5] = '{5'd31, 5'd31, 0, 1'b0, 1};
        vecs[6] = '{5'd0,  5'd31, 1, 1'b0, 32};
        vecs[7] = '{5'd12, 5'd20, 1, 1'b0, 9};
        for (int v = 0; v < 8; v++) begin
            do_dump(vecs[v].f, vecs[v].l, vecs[v].mode, vecs[v].exp_err, vecs[v].exp_words,
                    $sformatf("vec%0d", v));
            repeat ($urandom_range(0, 2)) tick();
        end

        for (int r = 0; r < 10; r++) begin
            rf = AW'($urandom_range(0, 31));
            rl = AW'($urandom_range(0, 31));
            do_dump(rf, rl, 1, (rf > rl), -1, $sformatf("rand%0d", r));
        end

        // Abort while word 4 of 1..10 waits in SEND.
        bus.out_ready = 1'b1;
        start = 1'b1;
        first_addr = 5'd1;
        last_addr = 5'd10;
        tick();
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (bus.out_valid && bus.out_addr == 5'd4) found = 1;
            else tick();
        end
        check("abort_reach_word4", found, 1'b1);
        bus.out_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", {busy, done, err, bus.out_valid}, 4'b0000);
        tick();
        check("abort_no_done", {busy, done, err}, 3'b000);
        abort = 1'b1;
        start = 1'b1;
        first_addr = 5'd2;
        last_addr = 5'd3;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_beats_start", {busy, done, err}, 3'b000);
        $display("abort sequence checked");
        do_dump(5'd7, 5'd7, 0, 1'b0, 1, "after_abort");

        // Reset while word 2 of 1..5 waits in SEND; start during reset is dropped.
        bus.out_ready = 1'b1;
        start = 1'b1;
        first_addr = 5'd1;
        last_addr = 5'd5;
        tick();
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (bus.out_valid && bus.out_addr == 5'd2) found = 1;
            else tick();
        end
        check("rst_reach_word2", found, 1'b1);
        bus.out_ready = 1'b0;
        rst = 1'b1;
        start = 1'b1;
        tick();
        check("rst_mid_dump", {busy, done, err, bus.out_valid, bus.out_addr, bus.out_data, rd_addr}, 64'h0);
        tick();
        rst = 1'b0;
        start = 1'b0;
        tick();
        check("rst_start_ignored", {busy, done, err, bus.out_valid}, 4'b0000);
        $display("reset sequence checked");
        do_dump(5'd1, 5'd3, 0, 1'b0, 3, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
